ripple_counter_ctrl: RTL and testbench

Sequencing controller for the user-area ripple counter. It accepts start/stop/clear/load commands over a valid/ready handshake and drives the counter's enable and clear. It compares the counter value against a programmable limit to run one-shot or continuous (auto-wrap) sequences. It raises an interrupt pulse on completion or wrap, and sits between the management-side command source and the counter datapath.

---
 rtl/ripple_ctrl_pkg.sv | 28 ++
 rtl/ripple_counter_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ripple_counter_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ripple_ctrl_pkg.sv
// ============================================================================
// Module   : ripple_ctrl_pkg
// Brief    : Shared state, command and mode encodings for ripple_counter_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ripple_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_LOAD  = 2'd3;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ripple_counter_ctrl.sv
// ============================================================================
// Module   : ripple_counter_ctrl
// Brief    : Command-driven sequencer for the ripple counter (one-shot/continuous).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_counter_ctrl
  import ripple_ctrl_pkg::*;
#(
  parameter int BITS  = 2,
  parameter int WRAPW = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_mode,
  input  logic [BITS-1:0]  cmd_data,
  input  logic [BITS-1:0]  cnt_q,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             irq,
  output logic             cmd_err,
  output logic [WRAPW-1:0] wrap_cnt
);

  state_t            r_state;
  logic [BITS-1:0]   r_limit;
  logic              r_mode;
  logic              r_to_run;
  logic [WRAPW-1:0]  r_wrap;
  logic              r_irq;
  logic              r_err;

  state_t            w_state_nxt;
  logic [BITS-1:0]   w_limit_nxt;
  logic              w_mode_nxt;
  logic              w_to_run_nxt;
  logic [WRAPW-1:0]  w_wrap_nxt;
  logic              w_irq_nxt;
  logic              w_err_nxt;

  logic              w_accept;
  logic              w_term;
  logic [WRAPW-1:0]  w_wrap_inc;

  assign cmd_ready = (r_state != ST_CLR);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_term    = (r_state == ST_RUN) && (cnt_q == r_limit);

  // On the terminal cycle the counter must not advance; in continuous mode it is cleared instead.
  assign cnt_en    = (r_state == ST_RUN) && !w_term;
  assign cnt_clr   = (r_state == ST_CLR) || (w_term && (r_mode == MODE_CONT));

  assign busy      = (r_state == ST_CLR) || (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign irq       = r_irq;
  assign cmd_err   = r_err;
  assign wrap_cnt  = r_wrap;

  assign w_wrap_inc = (r_wrap == {WRAPW{1'b1}}) ? r_wrap : r_wrap + WRAPW'(1);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state  <= ST_IDLE;
      r_limit  <= {BITS{1'b1}};
      r_mode   <= MODE_ONESHOT;
      r_to_run <= 1'b0;
      r_wrap   <= '0;
      r_irq    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_limit  <= w_limit_nxt;
      r_mode   <= w_mode_nxt;
      r_to_run <= w_to_run_nxt;
      r_wrap   <= w_wrap_nxt;
      r_irq    <= w_irq_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_limit_nxt  = r_limit;
    w_mode_nxt   = r_mode;
    w_to_run_nxt = r_to_run;
    w_wrap_nxt   = r_wrap;
    w_irq_nxt    = 1'b0;
    w_err_nxt    = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_START: begin
              w_state_nxt  = ST_CLR;
              w_to_run_nxt = 1'b1;
              w_mode_nxt   = cmd_mode;
              w_wrap_nxt   = '0;
            end
            OP_CLEAR: begin
              w_state_nxt  = ST_CLR;
              w_to_run_nxt = 1'b0;
              w_wrap_nxt   = '0;
            end
            OP_LOAD:  w_limit_nxt = cmd_data;
            default:  w_err_nxt   = 1'b1;
          endcase
        end
      end

      ST_CLR: begin
        w_state_nxt = r_to_run ? ST_RUN : ST_IDLE;
      end

      ST_RUN: begin
        if (w_term && (r_mode == MODE_CONT)) begin
          w_wrap_nxt = w_wrap_inc;
        end
        // STOP/CLEAR override the terminal transition and swallow its irq.
        if (w_accept && (cmd_op == OP_STOP)) begin
          w_state_nxt = ST_HOLD;
        end else if (w_accept && (cmd_op == OP_CLEAR)) begin
          w_state_nxt  = ST_CLR;
          w_to_run_nxt = 1'b0;
          w_wrap_nxt   = '0;
        end else begin
          w_err_nxt = w_accept;
          if (w_term) begin
            w_irq_nxt = 1'b1;
            if (r_mode == MODE_ONESHOT) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
      end

      ST_HOLD: begin
        if (w_accept) begin
          case (cmd_op)
            OP_START: w_state_nxt = ST_RUN;
            OP_CLEAR: begin
              w_state_nxt  = ST_CLR;
              w_to_run_nxt = 1'b0;
              w_wrap_nxt   = '0;
            end
            OP_LOAD:  w_limit_nxt = cmd_data;
            default:  w_err_nxt   = 1'b1;
          endcase
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ripple_counter_ctrl.sv
// ============================================================================
// Module   : tb_ripple_counter_ctrl
// Brief    : Scoreboard bench for ripple_counter_ctrl with a behavioural counter model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ripple_counter_ctrl;
  import ripple_ctrl_pkg::*;

  localparam int BITS  = 2;
  localparam int WRAPW = 8;
  localparam int VW    = 7 + WRAPW + BITS;
  localparam int P_IDLE = 0, P_CLR = 1, P_RUN = 2, P_HOLD = 3, P_DONE = 4;

  typedef logic [VW-1:0] vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic             cmd_mode = 1'b0;
  logic [BITS-1:0]  cmd_data = '0;
  logic [BITS-1:0]  cnt;
  logic             cnt_en, cnt_clr, busy, done, irq, cmd_err;
  logic [WRAPW-1:0] wrap_cnt;

  int errors = 0;
  int checks = 0;
  vec_t exp_q[$];

  // Behavioural model state
  int               m_ph;
  logic [BITS-1:0]  m_limit, m_cnt;
  logic             m_mode, m_to_run, m_irq, m_err;
  logic [WRAPW-1:0] m_wrap;

  always #5 clk = ~clk;

  ripple_counter_ctrl #(.BITS(BITS), .WRAPW(WRAPW)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_mode (cmd_mode),
    .cmd_data (cmd_data),
    .cnt_q    (cnt),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .busy     (busy),
    .done     (done),
    .irq      (irq),
    .cmd_err  (cmd_err),
    .wrap_cnt (wrap_cnt)
  );

  // Stand-in for the ripple counter datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_en)  cnt <= cnt + 1'b1;
  end

  function automatic vec_t pack(input logic rdy, input logic en, input logic clr, input logic bsy,
                                input logic dn, input logic iq, input logic er,
                                input logic [WRAPW-1:0] w, input logic [BITS-1:0] c);
    return {rdy, en, clr, bsy, dn, iq, er, w, c};
  endfunction

  always @(negedge clk) begin
    vec_t e;
    vec_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = pack(cmd_ready, cnt_en, cnt_clr, busy, done, irq, cmd_err, wrap_cnt, cnt);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t {rdy,en,clr,busy,done,irq,err,wrap,cnt} got=%b exp=%b", $time, a, e);
      end
    end
  end

  task automatic model_reset();
    m_ph = P_IDLE; m_limit = '1; m_mode = 1'b0; m_to_run = 1'b0;
    m_wrap = '0; m_irq = 1'b0; m_err = 1'b0; m_cnt = '0;
  endtask

  task automatic fresh(input logic to_run, input logic md);
    m_ph = P_CLR; m_to_run = to_run; m_wrap = '0;
    if (to_run) m_mode = md;
  endtask

  // One clock cycle: present inputs, queue expected outputs, then advance the model.
  task automatic cycle(input logic v, input logic [1:0] op, input logic md,
                       input logic [BITS-1:0] d, output logic acc);
    logic rdy, term, en, clr;
    cmd_valid = v; cmd_op = op; cmd_mode = md; cmd_data = d;
    rdy  = (m_ph != P_CLR);
    term = (m_ph == P_RUN) && (m_cnt == m_limit);
    en   = (m_ph == P_RUN) && !term;
    clr  = (m_ph == P_CLR) || (term && m_mode);
    exp_q.push_back(pack(rdy, en, clr, (m_ph == P_CLR) || (m_ph == P_RUN), m_ph == P_DONE,
                         m_irq, m_err, m_wrap, m_cnt));
    @(posedge clk);
    acc   = v && rdy;
    m_cnt = clr ? '0 : (en ? m_cnt + 1'b1 : m_cnt);
    m_irq = 1'b0;
    m_err = 1'b0;
    if (m_ph == P_CLR) begin
      m_ph = m_to_run ? P_RUN : P_IDLE;
    end else if (m_ph == P_RUN) begin
      if (term && m_mode && m_wrap != '1) m_wrap = m_wrap + 1'b1;
      if (acc && op == OP_STOP)       m_ph = P_HOLD;
      else if (acc && op == OP_CLEAR) fresh(1'b0, md);
      else begin
        m_err = acc;
        if (term) begin
          m_irq = 1'b1;
          if (!m_mode) m_ph = P_DONE;
        end
      end
    end else if (acc) begin
      if (op == OP_STOP)       m_err = 1'b1;
      else if (op == OP_LOAD)  m_limit = d;
      else if (op == OP_CLEAR) fresh(1'b0, md);
      else if (m_ph == P_HOLD) m_ph = P_RUN;
      else                     fresh(1'b1, md);
    end
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 1'b0, '0, acc);
    cmd_valid = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic md, input logic [BITS-1:0] d);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) cycle(1'b1, op, md, d, acc);
    cmd_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL cmd_accept op=%0d got=not_accepted exp=accepted", op);
    end
  endtask

  task automatic run_until_cnt(input logic [BITS-1:0] target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (m_ph == P_RUN && m_cnt == target) return;
      idle(1);
    end
    errors++;
    checks++;
    $display("FAIL wait_cnt got=timeout exp=cnt_q==%0d in RUN", target);
  endtask

  task automatic check_reset_outputs(input string name);
    logic [7+WRAPW-1:0] a, e;
    a = {cmd_ready, cnt_en, cnt_clr, busy, done, irq, cmd_err, wrap_cnt};
    e = {1'b1, 6'b0, {WRAPW{1'b0}}};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, a, e);
    end
  endtask

  initial begin
    logic acc;
    logic [1:0] r_op;
    logic r_md;
    logic [BITS-1:0] r_d;
    logic pend;

    model_reset();
    #3 check_reset_outputs("reset_values");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // One-shot to limit 2
    cmd(OP_LOAD, 1'b0, 2'd2);
    cmd(OP_START, MODE_ONESHOT, '0);
    idle(7);

    // Continuous with limit 3
    cmd(OP_LOAD, 1'b0, 2'd3);
    cmd(OP_START, MODE_CONT, '0);
    idle(11);

    // Pause and resume without clearing
    cmd(OP_CLEAR, 1'b0, '0);
    idle(1);
    cmd(OP_START, MODE_ONESHOT, '0);
    run_until_cnt(2'd1, 8);
    cmd(OP_STOP, 1'b0, '0);
    idle(5);
    cmd(OP_START, 1'b0, '0);
    idle(5);

    // Illegal commands
    cmd(OP_START, MODE_CONT, '0);
    idle(2);
    cmd(OP_LOAD, 1'b0, 2'd1);
    cmd(OP_START, MODE_ONESHOT, '0);
    cmd(OP_CLEAR, 1'b0, '0);
    idle(2);
    cmd(OP_STOP, 1'b0, '0);
    idle(2);

    // STOP landing on the continuous wrap cycle
    cmd(OP_START, MODE_CONT, '0);
    run_until_cnt(2'd3, 10);
    cmd(OP_STOP, 1'b0, '0);
    idle(3);

    // Asynchronous reset while running
    cmd(OP_START, 1'b0, '0);
    idle(2);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("async_reset_in_run");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmd(OP_START, MODE_ONESHOT, '0);
    idle(7);

    // limit 0: wrap saturation, then one-shot
    cmd(OP_LOAD, 1'b0, 2'd0);
    cmd(OP_START, MODE_CONT, '0);
    idle(270);
    cmd(OP_STOP, 1'b0, '0);
    cmd(OP_START, MODE_ONESHOT, '0);
    idle(2);
    cmd(OP_CLEAR, 1'b0, '0);
    cmd(OP_START, MODE_ONESHOT, '0);
    idle(4);

    // Randomized commands, held by the source until accepted
    pend = 1'b0;
    r_op = 2'd0; r_md = 1'b0; r_d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && ($urandom_range(0, 3) == 0)) begin
        pend = 1'b1;
        r_op = 2'($urandom_range(0, 3));
        r_md = 1'($urandom_range(0, 1));
        r_d  = BITS'($urandom_range(0, (1 << BITS) - 1));
      end
      cycle(pend, r_op, r_md, r_d, acc);
      if (acc) pend = 1'b0;
    end
    idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
